adc_spi_emulator: RTL and testbench
===================================

ADC_SPI_EMULATOR -- requirements
Module: adc_spi_emulator

Interface
REQ-001 Parameter NUM_SDI, default 4, number of SDI data lanes driven back to the controller; legal values 1, 2, 4, 8.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on spi_clk/spi_csn/spi_sdo; legal values 2..4.
REQ-003 Ports (clock and reset first):
- clk  input  1  system clock; frequency >= 8x SPI clock.
- resetn  input  1  reset; asynchronous, active-low.
- spi_clk  input  1  SPI clock from controller, idle low, asynchronous to clk.
- spi_csn  input  1  chip select from controller, active-low.
- spi_sdo  input  1  controller-to-device serial data, MSB first.
- spi_sdi  output  NUM_SDI  device-to-controller conversion data lanes.
- conv_data  input  32  next conversion word.
- conv_valid  input  1  conv_data valid.
- conv_ready  output  1  one-cycle pulse, conv_data consumed.
- reg_wr_valid  output  1  one-cycle pulse, register command received.
- reg_cmd  output  24  last received command, held until next.
- acq_done  output  1  one-cycle pulse, conversion frame completed.
- underrun  output  1  one-cycle pulse, frame started with no valid word.
- frame_error  output  1  one-cycle pulse, frame ended with illegal edge count.
- busy  output  1  high while state != IDLE.

Function
REQ-004 spi_clk, spi_csn, spi_sdo shall pass through SYNC_STAGES flops; all edge detection uses synchronized values; spi_csn synchronizer resets to 1, others to 0.
REQ-005 States: IDLE, XFER, FINISH; IDLE->XFER on synchronized spi_csn falling edge; XFER->FINISH on rising edge; FINISH->IDLE after exactly one cycle.
REQ-006 On IDLE->XFER: if conv_valid=1, load conv_data into 32-bit tx shifter and pulse conv_ready same cycle; else load last transmitted word and pulse underrun.
REQ-007 In XFER, spi_sdi shall present beat b (b=0 at entry) with lane k = word bit 31-b*NUM_SDI-k; beat 0 driven in the cycle after the falling-CSn detection.
REQ-008 Beat shall advance on each synchronized spi_clk falling edge; controller samples on rising edge.
REQ-009 On each synchronized spi_clk rising edge in XFER: shift spi_sdo into 24-bit rx shifter (LSB in), increment 6-bit edge counter, saturating at 63.
REQ-010 In FINISH: count==24 -> reg_cmd<=rx shifter, pulse reg_wr_valid; count==32/NUM_SDI -> pulse acq_done; any other count -> pulse frame_error, reg_cmd unchanged.
REQ-011 When 32/NUM_SDI==24 is impossible by parameter legality; count 24 is always a register write.
REQ-012 Beats beyond 32/NUM_SDI shall drive spi_sdi all zero.
REQ-013 spi_sdi shall be all zero in IDLE and FINISH.
REQ-014 spi_clk edges while synchronized spi_csn=1 shall be ignored.
REQ-015 CSn rise with count 0 shall give frame_error; no data consumed beyond REQ-006.
REQ-016 conv_valid asserted in the same cycle as CSn fall detection shall be captured.

Reset
REQ-017 resetn low shall asynchronously force: state IDLE, spi_sdi 0, all pulse outputs 0, busy 0, reg_cmd 0, shifters and counter 0, last-word register 0.
REQ-018 Reset mid-frame shall abort without any pulse; after release a new frame requires a fresh CSn falling edge.

Configuration
REQ-019 Macro ADC_EMU_TEST_PATTERN_EN defined: register command with reg_cmd[23]=0, reg_cmd[22:8]=0x0020 sets pattern_en=reg_cmd[0]; while pattern_en=1, REQ-006 loads an internal 32-bit counter (reset 0, +1 per acq_done) instead of conv_data, conv_ready and underrun never pulse.
REQ-020 Macro undefined: no pattern logic, all commands only forwarded on reg_cmd.

Verification
REQ-021 NUM_SDI=4, conv_data=0x12345678 valid, 8-clock frame -> lanes per beat 0x1,0x2,...,0x8 lane-reversed per REQ-007, controller word 0x12345678, acq_done once, conv_ready once.
REQ-022 24-clock frame, spi_sdo=0xA5C33C MSB first -> reg_wr_valid once, reg_cmd=0xA5C33C, spi_sdi all zero throughout.
REQ-023 conv_valid=0, 8-clock frame after word 0xDEADBEEF -> underrun pulse, retransmits 0xDEADBEEF.
REQ-024 CSn released after 5 clocks -> frame_error, no acq_done/reg_wr_valid, reg_cmd unchanged.
REQ-025 resetn low at clock 3 of a frame -> all outputs zero immediately, no pulses; next full frame correct.
REQ-026 With ADC_EMU_TEST_PATTERN_EN, write 0x002001 then three 8-clock frames -> words 0, 1, 2; without macro -> words from conv_data.

Source files
------------

// File: rtl/adc_spi_emulator.sv
// SPI ADC emulator: returns 32-bit conversion words over NUM_SDI lanes and captures 24-bit commands.
// Optional test-pattern source enabled by defining ADC_EMU_TEST_PATTERN_EN.
module adc_spi_emulator #(
    parameter int unsigned NUM_SDI     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               spi_clk,
    input  logic               spi_csn,
    input  logic               spi_sdo,
    output logic [NUM_SDI-1:0] spi_sdi,
    input  logic [31:0]        conv_data,
    input  logic               conv_valid,
    output logic               conv_ready,
    output logic               reg_wr_valid,
    output logic [23:0]        reg_cmd,
    output logic               acq_done,
    output logic               underrun,
    output logic               frame_error,
    output logic               busy
);

    localparam logic [5:0] AcqCount = 6'(32 / NUM_SDI);
    localparam logic [5:0] RegCount = 6'd24;

    typedef enum logic [1:0] {StIdle, StXfer, StFinish} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, csn_sync_q, sdo_sync_q, fill_q;
    logic                   sclk_prev_q, csn_prev_q, armed_q;
    logic [31:0]            tx_q, tx_d, last_q, last_d;
    logic [23:0]            rx_q, rx_d, reg_cmd_q, reg_cmd_d;
    logic [5:0]             cnt_q, cnt_d;

    logic sclk_s, csn_s, sdo_s;
    logic sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic start, reg_hit, acq_hit, pat_sel;
    logic [31:0] load_word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign sdo_s  = sdo_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q & ~csn_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q & ~csn_s;
    // A fall is only honoured once a genuine high CSn has propagated after reset.
    assign csn_fall  = armed_q & csn_prev_q & ~csn_s;
    assign csn_rise  = ~csn_prev_q & csn_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            sdo_sync_q  <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            sdo_sync_q  <= {sdo_sync_q[SYNC_STAGES-2:0], spi_sdo};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & csn_s);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (csn_fall) state_d = StXfer;
            StXfer:   if (csn_rise) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    assign start   = (state_q == StIdle) && csn_fall;
    assign reg_hit = (state_q == StFinish) && (cnt_q == RegCount);
    assign acq_hit = (state_q == StFinish) && (cnt_q == AcqCount);

`ifdef ADC_EMU_TEST_PATTERN_EN
    logic        pat_en_q, pat_en_d;
    logic [31:0] pat_cnt_q, pat_cnt_d;

    always_comb begin
        pat_en_d  = pat_en_q;
        pat_cnt_d = pat_cnt_q;
        if (reg_hit && !rx_q[23] && (rx_q[22:8] == 15'h0020)) pat_en_d = rx_q[0];
        if (acq_hit) pat_cnt_d = pat_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pat_en_q  <= 1'b0;
            pat_cnt_q <= '0;
        end else begin
            pat_en_q  <= pat_en_d;
            pat_cnt_q <= pat_cnt_d;
        end
    end

    assign pat_sel   = pat_en_q;
    assign load_word = pat_en_q ? pat_cnt_q : (conv_valid ? conv_data : last_q);
`else
    assign pat_sel   = 1'b0;
    assign load_word = conv_valid ? conv_data : last_q;
`endif

    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        reg_cmd_d = reg_cmd_q;
        if (start) begin
            tx_d   = load_word;
            last_d = load_word;
            rx_d   = '0;
            cnt_d  = '0;
        end else if (state_q == StXfer) begin
            // Zeros shift in behind the word, so late beats drive zero.
            if (sclk_fall) tx_d = {tx_q[31-NUM_SDI:0], {NUM_SDI{1'b0}}};
            if (sclk_rise) begin
                rx_d = {rx_q[22:0], sdo_s};
                if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
            end
        end
        if (reg_hit) reg_cmd_d = rx_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_q      <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            last_q    <= '0;
            reg_cmd_q <= '0;
        end else begin
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            reg_cmd_q <= reg_cmd_d;
        end
    end

    always_comb begin
        spi_sdi = '0;
        if (state_q == StXfer) begin
            for (int k = 0; k < int'(NUM_SDI); k++) spi_sdi[k] = tx_q[31-k];
        end
        conv_ready   = start & conv_valid & ~pat_sel;
        underrun     = start & ~conv_valid & ~pat_sel;
        reg_wr_valid = reg_hit;
        acq_done     = acq_hit;
        frame_error  = (state_q == StFinish) && !reg_hit && !acq_hit;
        busy         = (state_q != StIdle);
    end

    assign reg_cmd = reg_cmd_q;

endmodule

// File: tb/tb_adc_spi_emulator.sv
// Randomized/directed bench for adc_spi_emulator against a frame-level reference model.
// Honours ADC_EMU_TEST_PATTERN_EN in its expectations when defined.
module tb_adc_spi_emulator;

    localparam int N = 4;
    localparam int Half = 50;

    logic          clk = 1'b0;
    logic          resetn;
    logic          spi_clk, spi_csn, spi_sdo;
    logic [N-1:0]  spi_sdi;
    logic [31:0]   conv_data;
    logic          conv_valid;
    logic          conv_ready, reg_wr_valid, acq_done, underrun, frame_error, busy;
    logic [23:0]   reg_cmd;

    adc_spi_emulator #(.NUM_SDI(N), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_sdo(spi_sdo),
        .spi_sdi(spi_sdi), .conv_data(conv_data), .conv_valid(conv_valid),
        .conv_ready(conv_ready), .reg_wr_valid(reg_wr_valid), .reg_cmd(reg_cmd),
        .acq_done(acq_done), .underrun(underrun), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_ready = 0, n_under = 0, n_acq = 0, n_reg = 0, n_err = 0, n_idle_sdi = 0;

    always @(negedge clk) begin
        if (resetn) begin
            n_ready    += int'(conv_ready);
            n_under    += int'(underrun);
            n_acq      += int'(acq_done);
            n_reg      += int'(reg_wr_valid);
            n_err      += int'(frame_error);
            n_idle_sdi += int'(!busy && (spi_sdi != '0));
        end
    end

    // Reference model state
    logic [31:0] m_last = '0;
    logic [23:0] m_reg = '0;
    logic        m_pat = 1'b0;
    logic [31:0] m_pcnt = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = '0;
        m_reg  = '0;
        m_pat  = 1'b0;
        m_pcnt = '0;
    endtask

    // Drive one frame; check each beat against the lane formula and return the collected word.
    task automatic spi_frame(input int nclk, input logic [23:0] cmd, input logic [31:0] word,
                             output logic [31:0] got, output int beat_bad);
        logic [N-1:0] exp_lanes;
        got = '0;
        beat_bad = 0;
        spi_csn = 1'b0;
        #(Half + 10);
        for (int i = 0; i < nclk; i++) begin
            spi_sdo = (i < 24) ? cmd[23-i] : 1'b0;
            #(Half);
            for (int k = 0; k < N; k++) begin
                exp_lanes[k] = (i * N + k < 32) ? word[31-(i*N+k)] : 1'b0;
                got = {got[30:0], spi_sdi[k]};
            end
            if (spi_sdi !== exp_lanes) beat_bad++;
            spi_clk = 1'b1;
            #(Half);
            spi_clk = 1'b0;
        end
        #(Half);
        spi_csn = 1'b1;
        #(Half + 30);
    endtask

    task automatic run_frame(input string tag, input int nclk, input logic [23:0] cmd,
                             input logic [31:0] data, input logic valid);
        int r0, u0, a0, g0, e0, bad;
        logic [31:0] word, got;
        bit is_reg, is_acq;
        conv_data  = data;
        conv_valid = valid;
        if (m_pat) word = m_pcnt;
        else word = valid ? data : m_last;
        m_last = word;
        is_reg = (nclk == 24);
        is_acq = (nclk == 32 / N);
        r0 = n_ready; u0 = n_under; a0 = n_acq; g0 = n_reg; e0 = n_err;
        spi_frame(nclk, cmd, word, got, bad);
        conv_valid = 1'b0;
        chk({tag, ":beats"}, 64'(bad), 64'd0);
        chk({tag, ":ready"}, 64'(n_ready - r0), 64'((valid && !m_pat) ? 1 : 0));
        chk({tag, ":underrun"}, 64'(n_under - u0), 64'((!valid && !m_pat) ? 1 : 0));
        chk({tag, ":acq"}, 64'(n_acq - a0), 64'(is_acq ? 1 : 0));
        chk({tag, ":regwr"}, 64'(n_reg - g0), 64'(is_reg ? 1 : 0));
        chk({tag, ":ferr"}, 64'(n_err - e0), 64'((!is_reg && !is_acq) ? 1 : 0));
        if (is_reg) begin
            m_reg = cmd;
`ifdef ADC_EMU_TEST_PATTERN_EN
            if (!cmd[23] && cmd[22:8] == 15'h0020) m_pat = cmd[0];
`endif
        end
        if (is_acq) begin
            m_pcnt = m_pcnt + 32'd1;
            chk({tag, ":word"}, 64'(got), 64'(word));
        end
        chk({tag, ":regcmd"}, 64'(reg_cmd), 64'(m_reg));
        chk({tag, ":idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int r0, a0, g0, e0, nclk, sel;
        resetn = 1'b0; spi_clk = 1'b0; spi_csn = 1'b1; spi_sdo = 1'b0;
        conv_data = '0; conv_valid = 1'b0;
        #3;
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:sdi", 64'(spi_sdi), 64'd0);
        chk("rst:regcmd", 64'(reg_cmd), 64'd0);
        chk("rst:pulses", 64'({conv_ready, reg_wr_valid, acq_done, underrun, frame_error}), 64'd0);
        #30 resetn = 1'b1;
        #50;

        // Register write with nothing loaded yet: word 0 keeps SDI low throughout.
        run_frame("reg", 24, 24'hA5C33C, 32'h0, 1'b0);
        chk("reg:value", 64'(reg_cmd), 64'hA5C33C);
        run_frame("acq", 8, 24'h0, 32'h12345678, 1'b1);
        run_frame("acq2", 8, 24'h0, 32'hDEADBEEF, 1'b1);
        run_frame("under", 8, 24'h0, 32'h0BADF00D, 1'b0);
        run_frame("short5", 5, 24'h1F, 32'h11111111, 1'b1);
        run_frame("zero", 0, 24'h0, 32'h22222222, 1'b1);

        // Reset at clock 3 of a frame, with CSn held low across release.
        conv_data = 32'hCAFEF00D; conv_valid = 1'b1;
        spi_csn = 1'b0;
        #(Half + 10);
        for (int i = 0; i < 3; i++) begin
            #(Half) spi_clk = 1'b1;
            #(Half) spi_clk = 1'b0;
        end
        r0 = n_ready; a0 = n_acq; g0 = n_reg; e0 = n_err;
        resetn = 1'b0;
        #1;
        chk("midrst:busy", 64'(busy), 64'd0);
        chk("midrst:sdi", 64'(spi_sdi), 64'd0);
        chk("midrst:regcmd", 64'(reg_cmd), 64'd0);
        chk("midrst:pulses", 64'({conv_ready, reg_wr_valid, acq_done, underrun, frame_error}),
            64'd0);
        model_reset();
        #20 resetn = 1'b1;
        #150;
        chk("midrst:nostart", 64'(busy), 64'd0);
        chk("midrst:nopulse", 64'((n_ready - r0) + (n_acq - a0) + (n_reg - g0) + (n_err - e0)),
            64'd0);
        spi_csn = 1'b1;
        conv_valid = 1'b0;
        #80;

        // Pattern-enable command followed by three acquisitions.
        run_frame("patwr", 24, 24'h002001, 32'h33333333, 1'b1);
        for (int i = 0; i < 3; i++) run_frame("pat", 8, 24'h0, $urandom, 1'b1);

        for (int i = 0; i < 12; i++) begin
            sel = int'($urandom_range(0, 2));
            nclk = (sel == 0) ? 8 : (sel == 1) ? 24 : int'($urandom_range(0, 30));
            run_frame("rnd", nclk, 24'($urandom) & 24'h7FFFFF, $urandom, 1'($urandom));
        end

        chk("idle_sdi", 64'(n_idle_sdi), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
